// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: per-bit synchroniser, shared tick prescaler, and a
// per-bit stability counter that produces clean levels plus rise/fall pulses.

module switch_debouncer_bit #(
  parameter int STABLE_TICKS = 10,
  parameter int CW           = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_tick,
  input  logic i_sync,
  output logic o_accept,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);
  logic [CW-1:0] r_cnt;
  logic          r_stable, r_rise, r_fall;

  // A new level is taken only on the tick that completes the mismatch run.
  assign o_accept = i_tick && (i_sync != r_stable) && (r_cnt == CW'(STABLE_TICKS-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (i_load) begin
        r_stable <= i_sync;
        r_cnt    <= '0;
      end else if (i_tick) begin
        if (i_sync == r_stable) begin
          r_cnt <= '0;
        end else if (o_accept) begin
          r_stable <= i_sync;
          r_cnt    <= '0;
          r_rise   <= i_sync;
          r_fall   <= ~i_sync;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
endmodule

module switch_debouncer #(
  parameter int WIDTH        = 18,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change,
  output logic             ready
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS+1) : 1;
  localparam int IW = $clog2(SYNC_STAGES+1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                             r_state, w_state_nxt;
  logic [IW-1:0]                      r_init_cnt;
  logic [PW-1:0]                      r_presc;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  r_sync;
  logic                               r_any, r_ready;
  logic                               w_load, w_run, w_tick;
  logic [WIDTH-1:0]                   w_sync, w_accept, w_stable, w_rise, w_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], sw_raw};
  end
  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_INIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_init_cnt == IW'(SYNC_STAGES)) w_state_nxt = ST_RUN;
  end

  always_comb begin
    w_load = (r_state == ST_INIT) && (r_init_cnt == IW'(SYNC_STAGES));
    w_run  = (r_state == ST_RUN);
  end

  // Init waits for the synchroniser to fill before sampling power-up positions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_init_cnt <= '0;
    else if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + IW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_presc <= '0;
    else if (!w_run) r_presc <= '0;
    else if (r_presc == PW'(TICK_DIV-1)) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end
  assign w_tick = w_run && (r_presc == PW'(TICK_DIV-1));

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    switch_debouncer_bit #(.STABLE_TICKS(STABLE_TICKS), .CW(CW)) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_load   (w_load),
      .i_tick   (w_tick),
      .i_sync   (w_sync[g]),
      .o_accept (w_accept[g]),
      .o_stable (w_stable[g]),
      .o_rise   (w_rise[g]),
      .o_fall   (w_fall[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_any   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_any <= |w_accept;
      if (w_load) r_ready <= 1'b1;
    end
  end

  assign sw_stable  = w_stable;
  assign sw_rise    = w_rise;
  assign sw_fall    = w_fall;
  assign any_change = r_any;
  assign ready      = r_ready;
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed scenarios plus random toggling, checked every cycle against a
// cycle-level reference model of the debounce rules.

module tb_switch_debouncer;
  localparam int W  = 18;
  localparam int SS = 2;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic         any_change, ready;

  int checks = 0;
  int errors = 0;

  switch_debouncer #(.WIDTH(W), .SYNC_STAGES(SS), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .sw_stable  (sw_stable),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .any_change (any_change),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // Reference model: delay line for sync, edge counting for init, run-cycle
  // index modulo TICK_DIV for ticks, and a per-bit streak of mismatching ticks.
  logic [W-1:0] m_pipe [SS];
  logic [W-1:0] m_stable, m_rise, m_fall, m_old;
  logic         m_any, m_ready;
  int           m_edges, m_run_idx;
  int           m_streak [W];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SS; k++) m_pipe[k] = '0;
      for (int b = 0; b < W; b++) m_streak[b] = 0;
      m_stable = '0; m_rise = '0; m_fall = '0; m_any = 1'b0; m_ready = 1'b0;
      m_edges = 0; m_run_idx = 0;
    end else begin
      m_old = m_pipe[SS-1];
      for (int k = SS-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = sw_raw;
      m_rise = '0; m_fall = '0;
      m_edges++;
      if (!m_ready) begin
        if (m_edges == SS+1) begin
          m_stable = m_old; m_ready = 1'b1; m_run_idx = 0;
        end
      end else begin
        if (m_run_idx % TD == TD-1) begin
          for (int b = 0; b < W; b++) begin
            if (m_old[b] != m_stable[b]) begin
              m_streak[b]++;
              if (m_streak[b] == ST) begin
                m_streak[b] = 0;
                m_stable[b] = m_old[b];
                if (m_old[b]) m_rise[b] = 1'b1; else m_fall[b] = 1'b1;
              end
            end else m_streak[b] = 0;
          end
        end
        m_run_idx++;
      end
      m_any = |{m_rise, m_fall};
    end
  end

  int rise_cnt [W];
  int fall_cnt [W];
  int any_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int b = 0; b < W; b++) begin rise_cnt[b] = 0; fall_cnt[b] = 0; end
    any_cnt = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    chk("stable", 32'(sw_stable), 32'(m_stable));
    chk("rise",   32'(sw_rise),   32'(m_rise));
    chk("fall",   32'(sw_fall),   32'(m_fall));
    chk("any",    32'(any_change), 32'(m_any));
    chk("ready",  32'(ready),     32'(m_ready));
    for (int b = 0; b < W; b++) begin
      rise_cnt[b] += int'(sw_rise[b]);
      fall_cnt[b] += int'(sw_fall[b]);
    end
    any_cnt += int'(any_change);
  endtask

  int lat;
  int fall_sum;
  logic seen;
  logic [W-1:0] mask;

  initial begin
    clr();
    reset_n = 1'b0;
    sw_raw  = 18'h2A5A5;
    repeat (3) cyc();
    chk("rst_out", 32'({sw_stable, sw_rise, sw_fall, any_change, ready}), 32'(0));

    // Power-up load
    reset_n = 1'b1;
    cyc(); cyc();
    chk("pu_ready_early", 32'(ready), 32'(0));
    cyc();
    chk("pu_ready", 32'(ready), 32'(1));
    chk("pu_stable", 32'(sw_stable), 32'h2A5A5);
    chk("pu_no_pulse", 32'(any_cnt), 32'(0));

    // Settle to a known base for the directed scenarios
    sw_raw = 18'h20008;
    repeat (30) cyc();
    chk("base", 32'(sw_stable), 32'h20008);

    // Clean rise on bit 0
    clr(); lat = 0;
    sw_raw[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (sw_stable[0] && lat == 0) begin
        lat = i;
        chk("cr_rise", 32'(sw_rise), 32'h00001);
        chk("cr_any",  32'(any_change), 32'(1));
        chk("cr_fall", 32'(sw_fall), 32'(0));
      end
    end
    chk("cr_latency_ok", 32'(lat >= 11 && lat <= 14), 32'(1));
    chk("cr_any_once", 32'(any_cnt), 32'(1));

    // Bounce rejection on bit 5
    clr();
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) sw_raw[5] = ~sw_raw[5];
      cyc();
      chk("br_bit5", 32'(sw_stable[5]), 32'(0));
    end
    sw_raw[5] = 1'b0;
    repeat (20) cyc();
    chk("br_bit5_end", 32'(sw_stable[5]), 32'(0));
    chk("br_no_pulse", 32'(any_cnt), 32'(0));

    // Bounce then settle on bit 17
    clr(); lat = 0;
    sw_raw[17] = 1'b0; cyc(); cyc();
    sw_raw[17] = 1'b1; cyc(); cyc();
    sw_raw[17] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (sw_fall[17] && lat == 0) lat = i;
    end
    chk("bs_fall_once", 32'(fall_cnt[17]), 32'(1));
    chk("bs_no_rise", 32'(rise_cnt[17]), 32'(0));
    chk("bs_latency_ok", 32'(lat >= 1 && lat <= 14), 32'(1));
    chk("bs_bit17", 32'(sw_stable[17]), 32'(0));

    // Simultaneous multi-bit: bits 1,2 rise, bit 3 falls
    clr(); seen = 1'b0;
    sw_raw[1] = 1'b1; sw_raw[2] = 1'b1; sw_raw[3] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (any_change && !seen) begin
        seen = 1'b1;
        chk("mb_rise", 32'(sw_rise), 32'h00006);
        chk("mb_fall", 32'(sw_fall), 32'h00008);
      end
    end
    chk("mb_seen", 32'(seen), 32'(1));
    chk("mb_any_once", 32'(any_cnt), 32'(1));

    // Reset mid-debounce
    sw_raw[0] = 1'b0;
    repeat (6) cyc();
    reset_n = 1'b0;
    #1;
    chk("mr_stable0", 32'(sw_stable), 32'(0));
    chk("mr_pulses0", 32'({sw_rise, sw_fall, any_change}), 32'(0));
    chk("mr_ready0", 32'(ready), 32'(0));
    sw_raw = 18'h3FFFF;
    cyc(); cyc();
    clr();
    reset_n = 1'b1;
    cyc(); cyc();
    chk("mr_ready_early", 32'(ready), 32'(0));
    cyc();
    chk("mr_ready", 32'(ready), 32'(1));
    chk("mr_stable", 32'(sw_stable), 32'h3FFFF);
    repeat (20) cyc();
    chk("mr_no_pulse", 32'(any_cnt), 32'(0));

    // Random single-bit toggling against the model
    clr();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        mask = '0;
        mask[$urandom_range(0, W-1)] = 1'b1;
        sw_raw = sw_raw ^ mask;
      end
      cyc();
    end
    repeat (20) cyc();
    chk("rnd_final", 32'(sw_stable), 32'(sw_raw));
    fall_sum = 0;
    for (int b = 0; b < W; b++) fall_sum += fall_cnt[b];
    chk("rnd_activity", 32'(any_cnt > 0 && fall_sum > 0), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
